uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clocks per bit period (legal range 4..4095).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..8).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, transmit queue depth in bytes (power of two, 2..256).
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port wr_data  input  8  byte to queue; bits [7:DATA_BITS] are ignored.
REQ-009 SHALL have port wr_valid  input  1  write request.
REQ-010 SHALL have port wr_ready  output  1  queue can accept; a write occurs on a rising edge where wr_valid and wr_ready are both high.
REQ-011 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the frame being shifted.
REQ-012 SHALL have port tx_busy  output  1  high while a frame is on the line or the queue is non-empty.
REQ-013 SHALL have port txd  output  1  registered serial line, idle high.

Function
REQ-014 SHALL implement the FSM states IDLE, START, DATA, PAR and STOP; PAR SHALL be skipped when PARITY=0.
REQ-015 In IDLE with fifo_level>0, SHALL pop the head byte and enter START on the same edge; txd SHALL go low on that edge.
REQ-016 Latency: a byte accepted on edge k into an empty, idle block SHALL drive txd low on edge k+1.
REQ-017 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded with CLKS_PER_BIT-1 at every bit start.
REQ-018 Data SHALL be sent LSB first, DATA_BITS bits.
REQ-019 Parity bit SHALL make the count of ones in data plus parity odd (PARITY=1) or even (PARITY=2).
REQ-020 STOP SHALL drive txd high for STOP_BITS×CLKS_PER_BIT cycles.
REQ-021 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)×CLKS_PER_BIT cycles.
REQ-022 On the final stop-bit cycle, if the queue is non-empty, SHALL pop and begin the next START with no idle cycle; otherwise SHALL return to IDLE with txd high.
REQ-023 wr_ready SHALL equal (fifo_level<FIFO_DEPTH); when full, a write SHALL NOT be accepted even if a pop occurs on the same edge.
REQ-024 A simultaneous write and pop on a non-full queue SHALL leave fifo_level unchanged and keep byte order.
REQ-025 A write with wr_ready low SHALL be dropped with no change to state or data.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; bytes SHALL leave in acceptance order.
REQ-027 tx_busy SHALL be low only in IDLE with fifo_level=0.

Reset
REQ-028 When rst_n goes low, SHALL immediately, without waiting for clk, force txd=1, tx_busy=0, fifo_level=0, wr_ready=1 and state IDLE, and SHALL clear the pointers and bit/baud counters.
REQ-029 Reset mid-frame SHALL abort the frame and discard all queued bytes; no partial frame SHALL resume after release.
REQ-030 After rst_n rises, the first rising edge SHALL be able to accept a write.

Verification
REQ-031 Defaults, write 0x41 -> txd sequence 0,1,0,0,0,0,0,1,0,1, each bit 104 cycles, txd low on the edge after acceptance, tx_busy low 1040 cycles later.
REQ-032 PARITY=2, write 0x41 -> parity bit 0; PARITY=1 -> parity bit 1; frame length 1144 cycles.
REQ-033 Write 0x41 and 0x42 back-to-back -> two frames totalling 2080 cycles with no high gap between the first stop bit and the second start bit.
REQ-034 Hold the line busy and write 17 bytes into an empty queue -> fifo_level reaches 16, wr_ready goes low, the 17th byte is not accepted, and the 16 bytes are sent in order.
REQ-035 DATA_BITS=7, STOP_BITS=2, write 0xC1 -> data bits 1,0,0,0,0,0,1 followed by 2×CLKS_PER_BIT high cycles.
REQ-036 Assert rst_n low 500 cycles into a frame with 3 bytes queued -> txd=1 and fifo_level=0 with no clock edge needed; after release, txd stays high.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Purpose: byte-wide transmit queue feeding a UART serializer (start, LSB-first data, optional parity, stop bits).
// Latency: a byte accepted into an empty, idle block drives txd low on the next rising edge.
// Backpressure: wr_ready drops while the queue is full; writes presented then are dropped.
//
// Ports:
//   clk, rst_n         single clock, asynchronous active-low reset
//   wr_data/wr_valid   byte to queue and write request (bits above DATA_BITS ignored)
//   wr_ready           queue has room; write happens when wr_valid && wr_ready on a rising edge
//   fifo_level         bytes waiting, not counting the frame currently on the line
//   tx_busy            frame on the line or bytes waiting
//   txd                registered serial output, idle high

// Generic synchronous FIFO. Caller qualifies push (not full) and pop (not empty).
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    // Storage is not reset; only pointers and count define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + LW'(push) - LW'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign level = count;
endmodule

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_busy,
    output logic                          txd
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    DATA_MASK   = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]    LAST_DATA   = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP   = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;

    logic          push;
    logic          pop;
    logic          start_frame;
    logic          baud_end;
    logic [7:0]    fifo_dout;
    logic [7:0]    head;
    logic [LW-1:0] level;

    // Full queue refuses writes even if a pop happens on the same edge.
    assign wr_ready = (level < LW'(FIFO_DEPTH));
    assign push     = wr_valid && wr_ready;

    sync_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wr_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (level)
    );

    assign head     = fifo_dout & DATA_MASK;
    assign baud_end = (baud_q == '0);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        txd_d       = txd_q;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (level != '0) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    txd_d   = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            PAR: begin
                if (baud_end) begin
                    state_d = STOP;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    txd_d   = 1'b1;
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (bit_q == LAST_STOP) begin
                        // Chain straight into the next start bit when bytes are waiting.
                        if (level != '0) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        baud_d = BAUD_RELOAD;
                    end
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Pop the head byte and launch its start bit on this same edge.
        if (start_frame) begin
            state_d = START;
            baud_d  = BAUD_RELOAD;
            bit_d   = '0;
            shreg_d = head;
            // Odd mode inverts the even-parity XOR so data+parity has an odd count of ones.
            par_d   = (^head) ^ (PARITY == 1);
            txd_d   = 1'b0;
        end
    end

    assign pop = start_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    assign txd        = txd_q;
    assign fifo_level = level;
    assign tx_busy    = (state_q != IDLE) || (level != '0);
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int CPB = 104;

    logic       clk;
    logic       rst_n;
    logic [7:0] wr_data_w    [4];
    logic       wr_valid_w   [4];
    logic       wr_ready_w   [4];
    logic [4:0] fifo_level_w [4];
    logic       tx_busy_w    [4];
    logic       txd_w        [4];

    int checks;
    int failures;
    int len_r [4];

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] q3[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: defaults; dut1: even parity; dut2: odd parity; dut3: 7 data bits, 2 stop bits
    uart_tx_fifo u_dut0 (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data_w[0]), .wr_valid(wr_valid_w[0]),
        .wr_ready(wr_ready_w[0]), .fifo_level(fifo_level_w[0]), .tx_busy(tx_busy_w[0]), .txd(txd_w[0]));
    uart_tx_fifo #(.PARITY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data_w[1]), .wr_valid(wr_valid_w[1]),
        .wr_ready(wr_ready_w[1]), .fifo_level(fifo_level_w[1]), .tx_busy(tx_busy_w[1]), .txd(txd_w[1]));
    uart_tx_fifo #(.PARITY(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data_w[2]), .wr_valid(wr_valid_w[2]),
        .wr_ready(wr_ready_w[2]), .fifo_level(fifo_level_w[2]), .tx_busy(tx_busy_w[2]), .txd(txd_w[2]));
    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data_w[3]), .wr_valid(wr_valid_w[3]),
        .wr_ready(wr_ready_w[3]), .fifo_level(fifo_level_w[3]), .tx_busy(tx_busy_w[3]), .txd(txd_w[3]));

    function automatic int db_of(input int i);
        return (i == 3) ? 7 : 8;
    endfunction
    function automatic int par_of(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction
    function automatic int sb_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic int nb_of(input int i);
        return 1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i);
    endfunction

    // Line image of one frame, bit 0 first on the wire; unused upper bits stay 1.
    function automatic logic [15:0] frame(input logic [7:0] d, input int db, input int par);
        logic [15:0] f;
        int n;
        int ones;
        f = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int j = 0; j < db; j++) begin
            f[1 + j] = d[j];
            if (d[j]) ones++;
        end
        n = 1 + db;
        if (par == 1) f[n] = ~ones[0];
        else if (par == 2) f[n] = ones[0];
        return f;
    endfunction

    function automatic void push_exp(input int i, input logic [7:0] d);
        logic [15:0] f;
        f = frame(d, db_of(i), par_of(i));
        case (i)
            0: q0.push_back(f);
            1: q1.push_back(f);
            2: q2.push_back(f);
            default: q3.push_back(f);
        endcase
    endfunction

    function automatic bit pop_exp(input int i, output logic [15:0] f);
        f = '1;
        case (i)
            0: if (q0.size() > 0) begin f = q0.pop_front(); return 1'b1; end
            1: if (q1.size() > 0) begin f = q1.pop_front(); return 1'b1; end
            2: if (q2.size() > 0) begin f = q2.pop_front(); return 1'b1; end
            default: if (q3.size() > 0) begin f = q3.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    function automatic int q_size(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    // Counts edges until each DUT's tx_busy is seen low; -1 if the bound expires.
    task automatic measure_busy(input int bound);
        int n;
        bit all_done;
        for (int i = 0; i < 4; i++) len_r[i] = -1;
        n = 0;
        while (n < bound) begin
            @(posedge clk);
            #1;
            n++;
            all_done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (len_r[i] < 0) begin
                    if (!tx_busy_w[i]) len_r[i] = n;
                    else all_done = 1'b0;
                end
            end
            if (all_done) break;
        end
    endtask

    // Line monitors: on each start bit pop the expected frame and compare every cycle of every bit.
    for (genvar g = 0; g < 4; g++) begin : mon
        initial begin
            int cyc;
            int bidx;
            bit active;
            bit stray;
            bit bad;
            logic seen;
            logic [15:0] cur;
            active = 1'b0;
            stray  = 1'b0;
            bad    = 1'b0;
            cyc    = 0;
            seen   = 1'b1;
            cur    = '1;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    active = 1'b0;
                    stray  = 1'b0;
                end else begin
                    if (stray && txd_w[g]) stray = 1'b0;
                    if (!active && !stray && txd_w[g] == 1'b0) begin
                        if (pop_exp(g, cur)) begin
                            active = 1'b1;
                            cyc    = 0;
                            bad    = 1'b0;
                        end else begin
                            stray = 1'b1;
                            checks++;
                            failures++;
                            $display("FAIL dut%0d unexpected_frame got start bit required idle line", g);
                        end
                    end
                    if (active) begin
                        bidx = cyc / CPB;
                        if (txd_w[g] !== cur[bidx]) begin
                            bad  = 1'b1;
                            seen = txd_w[g];
                        end
                        if ((cyc % CPB) == CPB - 1) begin
                            checks++;
                            if (bad) begin
                                failures++;
                                $display("FAIL dut%0d line_bit%0d got %b required %b for all %0d cycles",
                                         g, bidx, seen, cur[bidx], CPB);
                            end
                            bad = 1'b0;
                        end
                        cyc++;
                        if (cyc == nb_of(g) * CPB) active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid_w[i] = 1'b0;
            wr_data_w[i]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_txd%0d", i), int'(txd_w[i]), 1);
            chk($sformatf("reset_busy%0d", i), int'(tx_busy_w[i]), 0);
            chk($sformatf("reset_level%0d", i), int'(fifo_level_w[i]), 0);
            chk($sformatf("reset_ready%0d", i), int'(wr_ready_w[i]), 1);
        end
        rst_n = 1'b1;

        // Single byte into every variant: 0x41 (0xC1 for the 7-bit variant)
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wr_valid_w[i] = 1'b1;
            wr_data_w[i]  = (i == 3) ? 8'hC1 : 8'h41;
            push_exp(i, wr_data_w[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) wr_valid_w[i] = 1'b0;
        chk("accept_level", int'(fifo_level_w[0]), 1);
        chk("accept_txd_idle", int'(txd_w[0]), 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("latency_txd_low%0d", i), int'(txd_w[i]), 0);
        chk("pop_level", int'(fifo_level_w[0]), 0);
        measure_busy(3000);
        chk("frame_len_default", len_r[0], 1040);
        chk("frame_len_even", len_r[1], 1144);
        chk("frame_len_odd", len_r[2], 1144);
        chk("frame_len_7d2s", len_r[3], 1040);

        // Back-to-back 0x41, 0x42: write and pop share an edge, frames chain with no gap
        @(negedge clk);
        wr_valid_w[0] = 1'b1;
        wr_data_w[0]  = 8'h41;
        push_exp(0, 8'h41);
        @(posedge clk);
        #1;
        wr_data_w[0] = 8'h42;
        push_exp(0, 8'h42);
        @(posedge clk);
        #1;
        wr_valid_w[0] = 1'b0;
        chk("b2b_level", int'(fifo_level_w[0]), 1);
        chk("b2b_txd_low", int'(txd_w[0]), 0);
        measure_busy(5000);
        chk("b2b_len", len_r[0], 2080);

        // Fill: 0x30 goes on the line, then 16 bytes fill the queue, 17th (0xEE) dropped
        @(negedge clk);
        wr_valid_w[0] = 1'b1;
        wr_data_w[0]  = 8'h30;
        push_exp(0, 8'h30);
        @(posedge clk);
        #1;
        for (int j = 0; j < 16; j++) begin
            wr_data_w[0] = 8'h80 + 8'(j);
            push_exp(0, wr_data_w[0]);
            @(posedge clk);
            #1;
        end
        chk("full_level", int'(fifo_level_w[0]), 16);
        chk("full_ready", int'(wr_ready_w[0]), 0);
        wr_data_w[0] = 8'hEE;
        @(posedge clk);
        #1;
        wr_valid_w[0] = 1'b0;
        chk("drop_level", int'(fifo_level_w[0]), 16);
        chk("drop_ready", int'(wr_ready_w[0]), 0);
        measure_busy(20000);
        chk("full_drain_len", len_r[0], 17664);
        chk("drain_ready", int'(wr_ready_w[0]), 1);

        // Reset 500 cycles into a frame (0x11) with 0x22, 0x33, 0x44 queued
        @(negedge clk);
        wr_valid_w[0] = 1'b1;
        wr_data_w[0]  = 8'h11;
        push_exp(0, 8'h11);
        @(posedge clk);
        #1;
        wr_data_w[0] = 8'h22;
        @(posedge clk);
        #1;
        wr_data_w[0] = 8'h33;
        @(posedge clk);
        #1;
        wr_data_w[0] = 8'h44;
        @(posedge clk);
        #1;
        wr_valid_w[0] = 1'b0;
        chk("queued3_level", int'(fifo_level_w[0]), 3);
        repeat (498) @(posedge clk);
        #3;
        chk("pre_reset_txd", int'(txd_w[0]), 0);
        rst_n = 1'b0;
        q0.delete();
        #1;
        chk("async_reset_txd", int'(txd_w[0]), 1);
        chk("async_reset_level", int'(fifo_level_w[0]), 0);
        chk("async_reset_busy", int'(tx_busy_w[0]), 0);
        chk("async_reset_ready", int'(wr_ready_w[0]), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (1200) begin
            @(negedge clk);
            if (txd_w[0] !== 1'b1 || tx_busy_w[0] !== 1'b0 || fifo_level_w[0] !== 5'd0) bad++;
        end
        chk("post_reset_idle_bad_cycles", bad, 0);

        // A write on the very first edge after release is accepted
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        wr_valid_w[0] = 1'b1;
        wr_data_w[0]  = 8'h5A;
        push_exp(0, 8'h5A);
        @(posedge clk);
        #1;
        wr_valid_w[0] = 1'b0;
        chk("first_edge_accept", int'(fifo_level_w[0]), 1);
        @(posedge clk);
        #1;
        chk("first_edge_txd_low", int'(txd_w[0]), 0);
        measure_busy(3000);
        chk("first_edge_len", len_r[0], 1040);

        repeat (5) @(posedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("pending_frames%0d", i), q_size(i), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
